// File: rtl/sram_controller_pkg.sv
// Shared types and defaults for the MEM-stage SRAM controller.
// Splits a 32-bit access into two 16-bit board-SRAM accesses.
package sram_controller_pkg;

    localparam int unsigned DEFAULT_ADDR_OFFSET = 1024;
    localparam int unsigned DEFAULT_WAIT_CYCLES = 5;
    localparam int unsigned DEFAULT_SRAM_AW     = 18;
    localparam int unsigned DATA_W              = 32;
    localparam int unsigned HALF_W              = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Request captured at the start of an access so a dropped request still finishes cleanly.
    typedef struct packed {
        logic              is_write;
        logic [DATA_W-1:0] wdata;
    } access_t;

    function automatic logic [HALF_W-1:0] half_word(input logic [DATA_W-1:0] word,
                                                    input logic              upper);
        return upper ? word[DATA_W-1:HALF_W] : word[HALF_W-1:0];
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage side of the SRAM controller: load/store request, load data and stall.
interface sram_controller_if;
    import sram_controller_pkg::*;

    logic              rd_en;
    logic              wr_en;
    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              sram_not_ready;

    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, sram_not_ready
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, sram_not_ready
    );

endinterface

// File: rtl/sram_half_timer.sv
// Cycle counter for one 16-bit SRAM access; flags the last cycle of the half.
module sram_half_timer #(
    parameter int unsigned WAIT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done_c
);

    localparam int unsigned CW = $clog2(WAIT_CYCLES);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_c = en && (count_q == CW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// Responder for 32-bit MEM-stage loads/stores on a 16-bit board SRAM.
// Low half first, then high half; stalls the pipeline until the access is done.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned ADDR_OFFSET = DEFAULT_ADDR_OFFSET,
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int unsigned SRAM_AW     = DEFAULT_SRAM_AW
) (
    input  logic                clk,
    input  logic                rst,
    sram_controller_if.slave    mem,
    output logic [SRAM_AW-1:0]  SRAM_ADDR,
    inout  wire  [HALF_W-1:0]   SRAM_DQ,
    output logic                SRAM_WE_N,
    output logic                SRAM_OE_N,
    output logic                SRAM_CE_N,
    output logic                SRAM_UB_N,
    output logic                SRAM_LB_N
);

    localparam int unsigned IDX_W = SRAM_AW - 1;

    state_e              state_q, state_d;
    access_t             acc_q, acc_d;
    logic [SRAM_AW-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]   read_data_q, read_data_d;

    logic [DATA_W-1:0]   offset_addr;
    logic [IDX_W-1:0]    idx;
    logic                unused_addr_bits;
    logic                req;
    logic                in_access;
    logic                half_done;
    logic                timer_clr;
    logic                we_n;
    logic                oe_n;
    logic                dq_oe;
    logic [HALF_W-1:0]   dq_out;

    assign req              = mem.rd_en | mem.wr_en;
    assign offset_addr      = mem.address - DATA_W'(ADDR_OFFSET);
    assign idx              = offset_addr[SRAM_AW:2];
    assign unused_addr_bits = ^{offset_addr[DATA_W-1:SRAM_AW+1], offset_addr[1:0]};
    assign in_access        = (state_q == ST_LOW) || (state_q == ST_HIGH);
    assign timer_clr        = (state_d != state_q);

    sram_half_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .en     (in_access),
        .done_c (half_done)
    );

    // Sequencing plus SRAM strobes; the last cycle of a write half holds address/data with WE_N high.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        addr_d      = addr_q;
        read_data_d = read_data_q;
        we_n        = 1'b1;
        oe_n        = 1'b1;
        dq_oe       = 1'b0;
        dq_out      = '0;

        if (in_access) begin
            if (acc_q.is_write) begin
                we_n   = half_done;
                dq_oe  = 1'b1;
                dq_out = half_word(acc_q.wdata, state_q == ST_HIGH);
            end else begin
                oe_n = 1'b0;
                if (half_done) begin
                    if (state_q == ST_HIGH) begin
                        read_data_d[DATA_W-1:HALF_W] = SRAM_DQ;
                    end else begin
                        read_data_d[HALF_W-1:0] = SRAM_DQ;
                    end
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d        = ST_LOW;
                    acc_d.is_write = mem.wr_en;
                    acc_d.wdata    = mem.write_data;
                    addr_d         = {idx, 1'b0};
                end
            end
            ST_LOW: begin
                if (half_done) begin
                    state_d = ST_HIGH;
                    addr_d  = {addr_q[SRAM_AW-1:1], 1'b1};
                end
            end
            ST_HIGH: begin
                if (half_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            addr_q      <= '0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            addr_q      <= addr_d;
            read_data_q <= read_data_d;
        end
    end

    // Stall rises combinationally with the request so the pipeline freezes that same cycle.
    assign mem.sram_not_ready = req && (state_q != ST_DONE);
    assign mem.read_data      = read_data_q;

    assign SRAM_DQ   = dq_oe ? dq_out : {HALF_W{1'bz}};
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n;
    assign SRAM_OE_N = oe_n;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed scenarios plus random loads/stores against a word-level model.
module tb_sram_controller;
    import sram_controller_pkg::*;

    localparam int unsigned W   = 5;
    localparam int unsigned AW  = 18;
    localparam int unsigned OFF = 1024;
    localparam int unsigned NTR = 2 * W + 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_controller_if mem_if ();

    wire  [15:0]   sram_dq;
    logic [AW-1:0] sram_addr;
    logic          we_n, oe_n, ce_n, ub_n, lb_n;

    sram_controller #(
        .ADDR_OFFSET (OFF),
        .WAIT_CYCLES (W),
        .SRAM_AW     (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem       (mem_if),
        .SRAM_ADDR (sram_addr),
        .SRAM_DQ   (sram_dq),
        .SRAM_WE_N (we_n),
        .SRAM_OE_N (oe_n),
        .SRAM_CE_N (ce_n),
        .SRAM_UB_N (ub_n),
        .SRAM_LB_N (lb_n)
    );

    // Board SRAM: pulled-up bus, drives on OE_N low, writes while WE_N low.
    logic [15:0] sram_mem [0:255];
    logic [15:0] model_out;
    assign model_out = sram_mem[sram_addr[7:0]];
    assign sram_dq   = oe_n ? 16'hzzzz : model_out;
    for (genvar gi = 0; gi < 16; gi++) begin : g_pull
        pullup (sram_dq[gi]);
    end
    always @(posedge clk) if (!we_n) sram_mem[sram_addr[7:0]] = sram_dq;

    // Reference: one 32-bit word per index.
    logic [31:0] ref_word [0:127];
    logic [31:0] exp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic          nr;
        logic          we_n;
        logic          oe_n;
        logic [AW-1:0] addr;
        logic [15:0]   dq;
        logic [31:0]   rdata;
    } obs_t;
    obs_t tr [$];

    // Runs one request, recording one sample per cycle until the stall drops.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, output bit timed_out);
        obs_t o;
        @(negedge clk);
        mem_if.rd_en      = rd;
        mem_if.wr_en      = wr;
        mem_if.address    = a;
        mem_if.write_data = d;
        tr.delete();
        timed_out = 1'b1;
        for (int c = 0; c < 4 * W + 10; c++) begin
            #1;
            o.nr    = mem_if.sram_not_ready;
            o.we_n  = we_n;
            o.oe_n  = oe_n;
            o.addr  = sram_addr;
            o.dq    = sram_dq;
            o.rdata = mem_if.read_data;
            tr.push_back(o);
            if (!o.nr) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        mem_if.rd_en = 1'b0;
        mem_if.wr_en = 1'b0;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_checks += 5;
            if (mem_if.sram_not_ready !== 1'b1) begin n_fail++; $display("FAIL reset_not_ready c%0d got %b want 1", c, mem_if.sram_not_ready); end
            if (we_n !== 1'b1) begin n_fail++; $display("FAIL reset_we_n c%0d got %b want 1", c, we_n); end
            if (oe_n !== 1'b1) begin n_fail++; $display("FAIL reset_oe_n c%0d got %b want 1", c, oe_n); end
            if (sram_dq !== 16'hFFFF) begin n_fail++; $display("FAIL reset_dq_z c%0d got %h want released", c, sram_dq); end
            if (sram_addr !== '0) begin n_fail++; $display("FAIL reset_addr c%0d got %h want 0", c, sram_addr); end
        end
        n_checks += 2;
        if (mem_if.read_data !== 32'h0) begin n_fail++; $display("FAIL reset_read_data got %h want 0", mem_if.read_data); end
        if ({ce_n, ub_n, lb_n} !== 3'b000) begin n_fail++; $display("FAIL tie_offs got %b want 000", {ce_n, ub_n, lb_n}); end
        @(negedge clk);
        mem_if.rd_en = 1'b0;
        rst          = 1'b0;
    endtask

    task automatic test_store_basic();
        bit to;
        int nr_cnt = 0;
        int bad    = 0;
        do_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, to);
        ref_word[0] = 32'hDEADBEEF;
        foreach (tr[k]) if (tr[k].nr) nr_cnt++;
        for (int k = 1; k <= 2 * W && k < tr.size(); k++) begin
            if (tr[k].addr !== AW'((k - 1) / W)) bad++;
        end
        n_checks += 5;
        if (to) begin n_fail++; $display("FAIL store_timeout no release within budget"); end
        if (nr_cnt != 2 * W + 1) begin n_fail++; $display("FAIL store_stall got %0d want %0d", nr_cnt, 2 * W + 1); end
        if (bad != 0) begin n_fail++; $display("FAIL store_addr_seq got %0d bad cycles want 0", bad); end
        if (sram_mem[0] !== 16'hBEEF) begin n_fail++; $display("FAIL store_low got %h want beef", sram_mem[0]); end
        if (sram_mem[1] !== 16'hDEAD) begin n_fail++; $display("FAIL store_high got %h want dead", sram_mem[1]); end
    endtask

    task automatic test_load_basic();
        bit to;
        do_access(1'b1, 1'b0, 32'd1024, 32'h0, to);
        exp_rdata = 32'hDEADBEEF;
        n_checks += 3;
        if (to) begin n_fail++; $display("FAIL load_timeout no release within budget"); end
        if (tr.size() != NTR) begin n_fail++; $display("FAIL load_release_cycle got %0d want %0d", tr.size(), NTR); end
        if (tr[tr.size()-1].rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_data got %h want deadbeef", tr[tr.size()-1].rdata); end
    endtask

    task automatic test_load_idx2();
        bit to;
        int bad_addr = 0;
        int bad_oe   = 0;
        int bad_dq   = 0;
        logic [31:0] w;
        w = ref_word[2];
        do_access(1'b1, 1'b0, 32'd1032, 32'h0, to);
        for (int k = 1; k <= 2 * W && k < tr.size(); k++) begin
            if (tr[k].addr !== AW'(4 + (k - 1) / W)) bad_addr++;
            if (tr[k].oe_n !== 1'b0 || tr[k].we_n !== 1'b1) bad_oe++;
            if (tr[k].dq !== ((k <= W) ? w[15:0] : w[31:16])) bad_dq++;
        end
        exp_rdata = w;
        n_checks += 5;
        if (to) begin n_fail++; $display("FAIL idx2_timeout no release within budget"); end
        if (bad_addr != 0) begin n_fail++; $display("FAIL idx2_addr got %0d bad cycles want 0", bad_addr); end
        if (bad_oe != 0) begin n_fail++; $display("FAIL idx2_strobes got %0d bad cycles want 0", bad_oe); end
        if (bad_dq != 0) begin n_fail++; $display("FAIL idx2_bus_contention got %0d bad cycles want 0", bad_dq); end
        if (tr[tr.size()-1].rdata !== w) begin n_fail++; $display("FAIL idx2_data got %h want %h", tr[tr.size()-1].rdata, w); end
    endtask

    task automatic test_rd_wr_both();
        bit to;
        int bad = 0;
        do_access(1'b1, 1'b1, 32'd1028, 32'h12345678, to);
        ref_word[1] = 32'h12345678;
        for (int k = 1; k <= 2 * W && k < tr.size(); k++) begin
            if (tr[k].addr !== AW'(2 + (k - 1) / W) || tr[k].oe_n !== 1'b1) bad++;
        end
        n_checks += 5;
        if (to) begin n_fail++; $display("FAIL both_timeout no release within budget"); end
        if (bad != 0) begin n_fail++; $display("FAIL both_bus got %0d bad cycles want 0", bad); end
        if (sram_mem[2] !== 16'h5678) begin n_fail++; $display("FAIL both_low got %h want 5678", sram_mem[2]); end
        if (sram_mem[3] !== 16'h1234) begin n_fail++; $display("FAIL both_high got %h want 1234", sram_mem[3]); end
        if (mem_if.read_data !== exp_rdata) begin n_fail++; $display("FAIL both_read_data got %h want %h", mem_if.read_data, exp_rdata); end
    endtask

    task automatic test_reset_mid_store();
        bit to;
        int nr_cnt = 0;
        @(negedge clk);
        mem_if.wr_en      = 1'b1;
        mem_if.address    = OFF + 400;
        mem_if.write_data = $urandom;
        repeat (W + 2) @(negedge clk);
        #1;
        n_checks++;
        if (we_n !== 1'b0 || sram_addr !== AW'(201)) begin n_fail++; $display("FAIL midrst_in_high got we_n=%b addr=%0d want 0/201", we_n, sram_addr); end
        rst          = 1'b1;
        mem_if.wr_en = 1'b0;
        @(negedge clk); #1;
        n_checks += 3;
        if (we_n !== 1'b1) begin n_fail++; $display("FAIL midrst_we_n got %b want 1", we_n); end
        if (oe_n !== 1'b1) begin n_fail++; $display("FAIL midrst_oe_n got %b want 1", oe_n); end
        if (sram_dq !== 16'hFFFF) begin n_fail++; $display("FAIL midrst_dq got %h want released", sram_dq); end
        rst = 1'b0;
        do_access(1'b1, 1'b0, OFF + 20, 32'h0, to);
        foreach (tr[k]) if (tr[k].nr) nr_cnt++;
        n_checks += 3;
        if (to) begin n_fail++; $display("FAIL postrst_timeout no release within budget"); end
        if (nr_cnt != 2 * W + 1) begin n_fail++; $display("FAIL postrst_stall got %0d want %0d", nr_cnt, 2 * W + 1); end
        if (mem_if.read_data !== ref_word[5]) begin n_fail++; $display("FAIL postrst_data got %h want %h", mem_if.read_data, ref_word[5]); end
        exp_rdata = ref_word[5];
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            bit          to;
            int          op;
            int          idx;
            int          nr_cnt;
            int          bad;
            logic        rd, wr;
            logic [31:0] d, w;
            op     = $urandom_range(0, 2);
            idx    = $urandom_range(0, 63);
            d      = $urandom;
            rd     = (op != 1);
            wr     = (op != 0);
            w      = ref_word[idx];
            nr_cnt = 0;
            bad    = 0;
            do_access(rd, wr, OFF + 32'(idx * 4) + 32'($urandom_range(0, 3)), d, to);
            foreach (tr[k]) if (tr[k].nr) nr_cnt++;
            for (int k = 1; k <= 2 * W && k < tr.size(); k++) begin
                int h;
                int cnt;
                h   = (k - 1) / W;
                cnt = (k - 1) % W;
                if (tr[k].addr !== AW'(idx * 2 + h)) bad++;
                if (wr) begin
                    if (tr[k].we_n !== (cnt == W - 1) || tr[k].oe_n !== 1'b1) bad++;
                    if (tr[k].dq !== (h ? d[31:16] : d[15:0])) bad++;
                end else begin
                    if (tr[k].oe_n !== 1'b0 || tr[k].we_n !== 1'b1) bad++;
                    if (tr[k].dq !== (h ? w[31:16] : w[15:0])) bad++;
                end
            end
            if (wr) ref_word[idx] = d;
            else    exp_rdata     = w;
            n_checks += 4;
            if (to) begin n_fail++; $display("FAIL rnd%0d_timeout no release within budget", t); end
            if (nr_cnt != 2 * W + 1) begin n_fail++; $display("FAIL rnd%0d_stall got %0d want %0d", t, nr_cnt, 2 * W + 1); end
            if (bad != 0) begin n_fail++; $display("FAIL rnd%0d_bus op%0d got %0d bad cycles want 0", t, op, bad); end
            if (mem_if.read_data !== exp_rdata) begin n_fail++; $display("FAIL rnd%0d_read_data op%0d got %h want %h", t, op, mem_if.read_data, exp_rdata); end
        end
    endtask

    initial begin
        rst               = 1'b1;
        mem_if.rd_en      = 1'b1;
        mem_if.wr_en      = 1'b0;
        mem_if.address    = 32'd1024;
        mem_if.write_data = 32'h0;
        for (int i = 0; i < 128; i++) begin
            ref_word[i]       = $urandom;
            sram_mem[2*i]     = ref_word[i][15:0];
            sram_mem[2*i + 1] = ref_word[i][31:16];
        end
        for (int i = 256 - 2; i < 256; i++) sram_mem[i] = 16'h0;
        exp_rdata = 32'h0;
        test_reset();
        test_store_basic();
        test_load_basic();
        test_load_idx2();
        test_rd_wr_both();
        test_reset_mid_store();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
